// File: rtl/spi_register_id_block_if.sv
// spi_register_id_block_if: byte-request handshake between the SPI layer and an ID register.
interface spi_register_id_block_if #(parameter int IW = 3);
  logic enable;
  logic byte_request;
  logic [7:0] data_out;
  logic data_out_valid;
  logic [IW-1:0] byte_index;
  logic overrun;
  modport master(output enable, byte_request, input data_out, data_out_valid, byte_index, overrun);
  modport slave(input enable, byte_request, output data_out, data_out_valid, byte_index, overrun);
endinterface

// File: rtl/spi_register_id_block.sv
// spi_register_id_block: multi-byte read-only ID register, MSB-first, with wrap/overrun.
// Define SPI_ID_CHECKSUM_EN to append an XOR checksum byte after the ID bytes.
module spi_register_id_block #(
  parameter int NUM_BYTES = 4,
  parameter logic [8*NUM_BYTES-1:0] ID_VALUE = 32'h0000_00AA,
  parameter bit WRAP = 1'b1
) (
  input logic clock,
  input logic reset,
  spi_register_id_block_if.slave bus
);
`ifdef SPI_ID_CHECKSUM_EN
  localparam int TOTAL = NUM_BYTES + 1;
`else
  localparam int TOTAL = NUM_BYTES;
`endif
  localparam int IW = $clog2(NUM_BYTES + 1) > 1 ? $clog2(NUM_BYTES + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);
  typedef enum logic [1:0] {IDLE, PRESENT, ADVANCE, DONE} state_t;
  state_t state, state_n;
  logic [7:0] data_q, data_n;
  logic valid_q, valid_n, overrun_q, overrun_n;
  logic [IW-1:0] index_q, index_n;
  function automatic logic [7:0] id_byte(input int i);
`ifdef SPI_ID_CHECKSUM_EN
    if (i >= NUM_BYTES) begin
      logic [7:0] x = '0;
      for (int j = 0; j < NUM_BYTES; j++) x ^= ID_VALUE[8*j +: 8];
      return x;
    end
`endif
    return ID_VALUE[8*(NUM_BYTES-1-i) +: 8];
  endfunction
  always_comb begin
    state_n = state;
    data_n = data_q;
    valid_n = valid_q;
    overrun_n = overrun_q;
    index_n = index_q;
    if (!bus.enable) begin
      state_n = IDLE;
      valid_n = 1'b0;
      index_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = PRESENT;
          data_n = id_byte(0);
          valid_n = 1'b1;
          index_n = '0;
          overrun_n = 1'b0;
        end
        PRESENT: begin
          if (bus.byte_request && index_q == LAST && !WRAP) begin
            state_n = DONE;
            data_n = 8'h00;
            valid_n = 1'b1;
            overrun_n = 1'b1;
          end else if (bus.byte_request) begin
            state_n = ADVANCE;
            valid_n = 1'b0;
            index_n = index_q == LAST ? '0 : index_q + IW'(1);
          end
        end
        ADVANCE: begin
          state_n = PRESENT;
          data_n = id_byte(int'(index_q));
          valid_n = 1'b1;
        end
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      data_q <= 8'h00;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      index_q <= '0;
    end else begin
      state <= state_n;
      data_q <= data_n;
      valid_q <= valid_n;
      overrun_q <= overrun_n;
      index_q <= index_n;
    end
  end
  assign bus.data_out = data_q;
  assign bus.data_out_valid = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.byte_index = index_q;
endmodule

// File: tb/tb_spi_register_id_block.sv
// tb_spi_register_id_block: three instances (1-byte AA, 4-byte wrap, 4-byte no-wrap) vs. a reference model.
module tb_spi_register_id_block;
  logic clock = 1'b0;
  logic reset, en, req;
  int n_pass = 0, n_total = 0;
  always #5 clock = ~clock;
  spi_register_id_block_if #(.IW(1)) b0();
  spi_register_id_block_if #(.IW(3)) b1();
  spi_register_id_block_if #(.IW(3)) b2();
  assign b0.enable = en;
  assign b1.enable = en;
  assign b2.enable = en;
  assign b0.byte_request = req;
  assign b1.byte_request = req;
  assign b2.byte_request = req;
  spi_register_id_block #(.NUM_BYTES(1), .ID_VALUE(8'hAA), .WRAP(1'b1)) d0 (.clock(clock), .reset(reset), .bus(b0));
  spi_register_id_block #(.NUM_BYTES(4), .ID_VALUE(32'h12345678), .WRAP(1'b1)) d1 (.clock(clock), .reset(reset), .bus(b1));
  spi_register_id_block #(.NUM_BYTES(4), .ID_VALUE(32'h12345678), .WRAP(1'b0)) d2 (.clock(clock), .reset(reset), .bus(b2));
  logic [7:0] o_data[3];
  logic o_valid[3], o_ovr[3];
  logic [3:0] o_idx[3];
  assign o_data[0] = b0.data_out;
  assign o_data[1] = b1.data_out;
  assign o_data[2] = b2.data_out;
  assign o_valid[0] = b0.data_out_valid;
  assign o_valid[1] = b1.data_out_valid;
  assign o_valid[2] = b2.data_out_valid;
  assign o_ovr[0] = b0.overrun;
  assign o_ovr[1] = b1.overrun;
  assign o_ovr[2] = b2.overrun;
  assign o_idx[0] = {3'b000, b0.byte_index};
  assign o_idx[1] = {1'b0, b1.byte_index};
  assign o_idx[2] = {1'b0, b2.byte_index};
  logic [7:0] tbl[3][6];
  int tot[3];
  bit wr[3];
  int m_idx[3];
  logic [7:0] m_data[3];
  bit m_valid[3], m_ovr[3], m_active[3], m_gap[3], m_done[3];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_idx[i] = 0; m_data[i] = 8'h00; m_valid[i] = 0; m_ovr[i] = 0;
        m_active[i] = 0; m_gap[i] = 0; m_done[i] = 0;
      end else if (!en) begin
        m_active[i] = 0; m_gap[i] = 0; m_done[i] = 0; m_valid[i] = 0; m_idx[i] = 0;
      end else if (!m_active[i]) begin
        m_active[i] = 1; m_idx[i] = 0; m_data[i] = tbl[i][0]; m_valid[i] = 1; m_ovr[i] = 0;
      end else if (m_done[i]) begin
      end else if (m_gap[i]) begin
        m_gap[i] = 0; m_data[i] = tbl[i][m_idx[i]]; m_valid[i] = 1;
      end else if (req) begin
        if (m_idx[i] == tot[i] - 1 && !wr[i]) begin
          m_done[i] = 1; m_data[i] = 8'h00; m_valid[i] = 1; m_ovr[i] = 1;
        end else begin
          m_idx[i] = (m_idx[i] + 1) % tot[i]; m_gap[i] = 1; m_valid[i] = 0;
        end
      end
    end
  endtask
  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("data%0d", i), 32'(o_data[i]), 32'(m_data[i]));
      check($sformatf("valid%0d", i), 32'(o_valid[i]), 32'(m_valid[i]));
      check($sformatf("index%0d", i), 32'(o_idx[i]), 32'(m_idx[i]));
      check($sformatf("overrun%0d", i), 32'(o_ovr[i]), 32'(m_ovr[i]));
    end
  endtask
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask
  initial begin
    logic [7:0] id[4];
    logic [7:0] cs;
    id = '{8'h12, 8'h34, 8'h56, 8'h78};
    cs = 8'h00;
    tbl[0][0] = 8'hAA;
    tot[0] = 1;
    for (int b = 0; b < 4; b++) begin
      tbl[1][b] = id[b];
      tbl[2][b] = id[b];
      cs ^= id[b];
    end
    tot[1] = 4;
`ifdef SPI_ID_CHECKSUM_EN
    tbl[0][1] = 8'hAA;
    tot[0] = 2;
    tbl[1][4] = cs;
    tbl[2][4] = cs;
    tot[1] = 5;
`endif
    tot[2] = tot[1];
    wr = '{1'b1, 1'b1, 1'b0};
    en = 1'b1; req = 1'b0; reset = 1'b1;
    #1;
    check("rst_data", 32'(o_data[1]), 0);
    check("rst_valid", 32'(o_valid[1]), 0);
    check("rst_index", 32'(o_idx[1]), 0);
    check("rst_overrun", 32'(o_ovr[1]), 0);
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("first_byte", 32'(o_data[0]), 32'h AA);
    check("first_valid", 32'(o_valid[0]), 1);
    check("first_byte_id", 32'(o_data[1]), 32'h12);
    for (int k = 0; k < 5; k++) begin
      req = 1'b1;
      cycle();
      req = 1'b0;
      check("adv_valid_low", 32'(o_valid[1]), 0);
      cycle();
      check("seq_byte", 32'(o_data[1]), 32'(tbl[1][(k + 1) % tot[1]]));
      check("seq_index", 32'(o_idx[1]), 32'((k + 1) % tot[1]));
      check("seq_valid", 32'(o_valid[1]), 1);
`ifdef SPI_ID_CHECKSUM_EN
      if (k == 3) check("checksum_byte", 32'(o_data[1]), 32'h08);
`else
      if (k == 3) check("wrap_to_first", 32'(o_data[1]), 32'h12);
`endif
      repeat (2) cycle();
    end
    check("done_data", 32'(o_data[2]), 0);
    check("done_overrun", 32'(o_ovr[2]), 1);
    check("done_valid", 32'(o_valid[2]), 1);
    req = 1'b1;
    cycle();
    req = 1'b0;
    cycle();
    check("done_hold_index", 32'(o_idx[2]), 32'(tot[2] - 1));
    check("done_hold_data", 32'(o_data[2]), 0);
    en = 1'b0;
    cycle();
    check("idle_overrun_held", 32'(o_ovr[2]), 1);
    check("idle_valid", 32'(o_valid[2]), 0);
    check("idle_index", 32'(o_idx[2]), 0);
    en = 1'b1;
    cycle();
    check("reenable_overrun", 32'(o_ovr[2]), 0);
    check("reenable_byte", 32'(o_data[2]), 32'h12);
    repeat (2) begin
      req = 1'b1;
      cycle();
      req = 1'b0;
      repeat (3) cycle();
    end
    check("at_byte2", 32'(o_idx[1]), 2);
    en = 1'b0; req = 1'b1;
    cycle();
    req = 1'b0;
    check("drop_valid", 32'(o_valid[1]), 0);
    check("drop_index", 32'(o_idx[1]), 0);
    en = 1'b1;
    cycle();
    check("restart_byte", 32'(o_data[1]), 32'h12);
    repeat (2) cycle();
    req = 1'b1;
    repeat (2) cycle();
    req = 1'b0;
    repeat (2) cycle();
    check("b2b_index", 32'(o_idx[1]), 1);
    check("b2b_byte", 32'(o_data[1]), 32'h34);
    for (int c = 0; c < 3000; c++) begin
      en = $urandom_range(0, 19) != 0;
      req = $urandom_range(0, 2) == 0;
      reset = $urandom_range(0, 299) == 0;
      cycle();
    end
    reset = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spi_register_id_block.md
# spi_register_id_block

Parametrised, multi-byte read-only identification register for the FPGA SPI register map. When its register address is selected, the SPI layer reads it one byte at a time: chip ID, revision, and build bytes from a compile-time constant, presented MSB-first. A byte-request handshake advances through the bytes, with wrap or overrun behaviour at the end. It generalises the single-byte chip-ID register to N bytes, with sequencing and an optional checksum byte.

## Interface
Parameters:
- NUM_BYTES, default 4: number of ID bytes; legal range 1..16.
- ID_VALUE, default 32'h0000_00AA: ID constant, width 8*NUM_BYTES; byte 0 = ID_VALUE[8*NUM_BYTES-1 -: 8].
- WRAP, default 1: 1 = wrap to byte 0 after the last byte; 0 = stop and flag overrun.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  high while this register is addressed by the SPI transaction.
- byte_request  in  1  single-cycle pulse from the SPI layer: current byte consumed, present the next.
- data_out  out  8  byte currently presented.
- data_out_valid  out  1  data_out holds a valid byte.
- byte_index  out  IW  index of the presented byte; IW = max(1, $clog2(NUM_BYTES+1)).
- overrun  out  1  sticky; read past the last byte with WRAP=0.

## Operation
- TOTAL = NUM_BYTES, or NUM_BYTES+1 when the checksum is compiled in (see Configuration).
- States: IDLE, PRESENT, ADVANCE, DONE.
- IDLE: valid=0, index=0. First edge with enable=1: data_out=byte 0, valid=1, go to PRESENT.
- PRESENT: valid=1. byte_request=1: valid=0 and go to ADVANCE.
  - Index below TOTAL-1: index increments.
  - Index at TOTAL-1 with WRAP=1: index becomes 0.
  - Index at TOTAL-1 with WRAP=0: go to DONE instead of ADVANCE.
- ADVANCE: exactly one cycle. Next edge: data_out=byte[index], valid=1, go to PRESENT.
- DONE: data_out=8'h00, valid=1, overrun=1, index held at TOTAL-1. Further requests are ignored; outputs stay unchanged.
- enable=0 in any state: next edge goes to IDLE with valid=0 and index=0. data_out holds its last value. overrun holds.
- overrun clears only on reset or on the IDLE->PRESENT transition.
- Simultaneous enable=0 and byte_request=1: enable wins; no advance.
- byte_request in IDLE, ADVANCE or DONE: ignored. It is not queued.
- Reset asserted mid-sequence: all outputs go to reset values immediately. A new sequence starts from byte 0.

## Timing
- Reset values: data_out=8'h00, data_out_valid=0, byte_index=0, overrun=0, state=IDLE.
- First byte: valid one cycle after enable is first sampled high.
- Request to next byte valid: 2 cycles. Valid is low for exactly the 1 ADVANCE cycle.
- Sustained rate: one byte per 2 clocks. The SPI layer must space requests at least 2 cycles apart; closer requests are dropped.
- Request at the last byte with WRAP=0: DONE one cycle later, with overrun=1 and valid=1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SPI_ID_CHECKSUM_EN defined:
  - Adds one byte at index NUM_BYTES: the XOR of all NUM_BYTES ID bytes.
  - TOTAL = NUM_BYTES+1; wrap and overrun apply after the checksum byte.
- Not defined: TOTAL = NUM_BYTES; no checksum logic is synthesised.

## Test plan
- Reset: pulse reset for 3 cycles, with enable held high during it -> data_out=00, valid=0, index=0, overrun=0; valid=1 with byte AA one cycle after reset releases.
- NUM_BYTES=4, ID_VALUE=32'h12345678, WRAP=1, no checksum. Raise enable, then issue 5 requests spaced 4 cycles apart -> bytes 12,34,56,78,12,34 with index 0,1,2,3,0,1; valid low exactly 1 cycle after each request.
- Same ID with WRAP=0, 4 requests -> after 78 comes DONE with data_out=00, overrun=1, valid=1. A further request changes nothing. Dropping and re-raising enable clears overrun and presents 12.
- SPI_ID_CHECKSUM_EN, ID 32'h12345678 -> index 4 presents byte 08 (12^34^56^78). The next request wraps to 12.
- Drop enable in the same cycle as a request during the byte-2 PRESENT state -> IDLE, valid=0, index=0. Re-enable presents 12, not 78.
- Back-to-back requests on consecutive cycles -> the second, arriving in ADVANCE, is ignored; the index advances by 1 only.
